// File: rtl/phys_free_list_pkg.sv
// ----------------------------------------------------------------------------
// phys_free_list_pkg
//   Shared sizing constants, types and helpers for the physical register
//   free list.
//   NUM_PHYS : physical registers in the register file
//   NUM_ARCH : architectural registers; tags 0..NUM_ARCH-1 hold the reset map
//   TAG_W    : physical tag width
//   DEPTH    : free-list capacity, always NUM_PHYS - NUM_ARCH
//   IDX_W    : storage index width
//   PTR_W    : pointer width, one extra MSB used as the wrap bit
// ----------------------------------------------------------------------------
package phys_free_list_pkg;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int TAG_W    = $clog2(NUM_PHYS);
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // Storage index of a wrap-bit pointer: drop the wrap bit.
    function automatic idx_t ptr_idx(input ptr_t p);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/phys_free_list_mem.sv
// ----------------------------------------------------------------------------
// phys_free_list_mem
//   Tag storage for the free list. One synchronous write port, one
//   combinational read port. Reset loads the initial free tags
//   NUM_ARCH .. NUM_PHYS-1 into slots 0 .. DEPTH-1.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     wr_en      : write wr_data into slot wr_idx at the clock edge
//     wr_idx     : write slot
//     wr_data    : tag to store
//     rd_idx     : read slot
//     rd_data    : tag stored at rd_idx (reflects registered contents only)
// ----------------------------------------------------------------------------
module phys_free_list_mem
    import phys_free_list_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  idx_t wr_idx,
    input  tag_t wr_data,
    input  idx_t rd_idx,
    output tag_t rd_data
);

    tag_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read is from registered contents; a same-cycle write is not bypassed.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/phys_free_list.sv
// ----------------------------------------------------------------------------
// phys_free_list
//   Circular free list of physical register tags. Rename pops one tag per
//   cycle from the speculative head; commit pushes superseded tags at the
//   tail and advances a committed head. Flush rewinds the speculative head
//   to the committed head, reclaiming every speculative allocation at once.
//   Ports:
//     clk, reset    : clock and synchronous active-high reset
//     stall         : pipeline stall, blocks allocation only
//     alloc_req     : rename wants one destination tag
//     alloc_valid   : list non-empty, alloc_tag is meaningful
//     alloc_tag     : tag at the speculative head
//     commit_alloc  : retiring instruction had allocated; advance committed head
//     free_req      : retiring instruction releases free_tag
//     free_tag      : tag being released
//     flush         : recovery; speculative head returns to committed head
//     free_count    : speculative free entries, 0..DEPTH
//     err           : one-cycle pulse after a free into a full list or a
//                     commit with nothing speculative outstanding
// ----------------------------------------------------------------------------
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       alloc_req,
    output logic       alloc_valid,
    output tag_t       alloc_tag,
    input  logic       commit_alloc,
    input  logic       free_req,
    input  tag_t       free_tag,
    input  logic       flush,
    output tag_t       free_count,
    output logic       err
);

    ptr_t head, head_next;
    ptr_t tail, tail_next;
    ptr_t chead, chead_next;
    ptr_t occupancy;

    logic full;
    logic grant;
    logic free_ok, free_err;
    logic commit_ok, commit_err;

    // Pointers carry a wrap bit, so the modular difference is the exact
    // number of free entries, including the full (DEPTH) case.
    assign occupancy   = tail - head;
    assign free_count  = TAG_W'(occupancy);
    assign alloc_valid = (occupancy != '0);
    assign full        = (occupancy == PTR_W'(DEPTH));

    // Allocation is the only operation blocked by stall; flush also blocks it
    // because the head is being rewritten this cycle.
    assign grant = alloc_req & alloc_valid & ~stall & ~flush;

    // A free into a full list is dropped. Fullness is judged on registered
    // state, so a same-cycle allocation does not make room.
    assign free_ok  = free_req & ~full;
    assign free_err = free_req & full;

    // Committed head may never pass the speculative head.
    assign commit_ok  = commit_alloc & (chead != head);
    assign commit_err = commit_alloc & (chead == head);

    always_comb begin
        chead_next = chead;
        if (commit_ok) begin
            chead_next = chead + ptr_t'(1);
        end
    end

    always_comb begin
        tail_next = tail;
        if (free_ok) begin
            tail_next = tail + ptr_t'(1);
        end
    end

    // Flush lands on the committed head including this cycle's commit.
    always_comb begin
        head_next = head;
        if (flush) begin
            head_next = chead_next;
        end else if (grant) begin
            head_next = head + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            chead <= '0;
            tail  <= PTR_W'(DEPTH);
            err   <= 1'b0;
        end else begin
            head  <= head_next;
            chead <= chead_next;
            tail  <= tail_next;
            err   <= free_err | commit_err;
        end
    end

    phys_free_list_mem u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (free_ok),
        .wr_idx  (ptr_idx(tail)),
        .wr_data (free_tag),
        .rd_idx  (ptr_idx(head)),
        .rd_data (alloc_tag)
    );

endmodule

// File: tb/tb_phys_free_list.sv
// ----------------------------------------------------------------------------
// tb_phys_free_list
//   Directed bench for phys_free_list. Each driven cycle pushes the expected
//   registered status for that cycle into st_q and, when an allocation is
//   expected to be granted, the expected tag into exp_q. A monitor on the
//   falling edge pops and compares independently of the driver.
// ----------------------------------------------------------------------------
module tb_phys_free_list;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       commit_alloc;
    logic       free_req;
    logic [5:0] free_tag;
    logic       flush;
    logic [5:0] free_count;
    logic       err;

    typedef struct {
        int         id;
        logic [5:0] fc;
        logic       av;
        logic [5:0] tag;
        logic       chk_tag;
        logic       err;
    } status_t;

    logic [5:0] exp_q[$];
    status_t    st_q[$];

    int tests  = 0;
    int errors = 0;
    int step_id = 0;

    phys_free_list dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .commit_alloc (commit_alloc),
        .free_req     (free_req),
        .free_tag     (free_tag),
        .flush        (flush),
        .free_count   (free_count),
        .err          (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall        = 1'b0;
        alloc_req    = 1'b0;
        commit_alloc = 1'b0;
        free_req     = 1'b0;
        free_tag     = '0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs and record what the DUT must show during it.
    task automatic step(input logic a, input logic fr, input logic [5:0] ft,
                        input logic cm, input logic fl, input logic st,
                        input logic [5:0] e_fc, input logic e_av,
                        input logic [5:0] e_tag, input logic e_chk,
                        input logic e_err, input logic e_grant);
        status_t s;
        alloc_req    = a;
        free_req     = fr;
        free_tag     = ft;
        commit_alloc = cm;
        flush        = fl;
        stall        = st;
        step_id++;
        s.id      = step_id;
        s.fc      = e_fc;
        s.av      = e_av;
        s.tag     = e_tag;
        s.chk_tag = e_chk;
        s.err     = e_err;
        st_q.push_back(s);
        if (e_grant) exp_q.push_back(e_tag);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (st_q.size() > 0) begin
                status_t s;
                s = st_q.pop_front();
                tests++;
                if (free_count !== s.fc || alloc_valid !== s.av || err !== s.err ||
                    (s.chk_tag && alloc_tag !== s.tag)) begin
                    errors++;
                    $display("FAIL status step %0d: got fc=%0d av=%0b tag=%0d err=%0b, want fc=%0d av=%0b tag=%0d(chk=%0b) err=%0b",
                             s.id, free_count, alloc_valid, alloc_tag, err,
                             s.fc, s.av, s.tag, s.chk_tag, s.err);
                end
            end
            if (alloc_req && alloc_valid && !stall && !flush) begin
                tests++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant step %0d: got unexpected grant of tag %0d, want no grant",
                             step_id, alloc_tag);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    if (alloc_tag !== e) begin
                        errors++;
                        $display("FAIL grant_tag step %0d: got %0d, want %0d", step_id, alloc_tag, e);
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        clear_inputs();
        do_reset();

        // Drain the whole list: tags 32..63 in order, then an ungranted request.
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 0, 0, 0, 0, 6'(32 - i), 1, 6'(32 + i), 1, 0, 1);
        end
        step(1, 0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 0);

        // Free into an empty list: visible only on the following cycle.
        step(0, 1, 6'd5, 0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'd1, 1, 6'd5, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 6'd1, 1, 6'd5, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 0);

        // Alloc 3, commit 1, flush: head rewinds to the committed head.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 6'd32, 1, 6'd32, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 6'd31, 1, 6'd33, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 6'd30, 1, 6'd34, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 6'd29, 1, 6'd35, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 6'd29, 1, 6'd35, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'd31, 1, 6'd33, 1, 0, 0);

        // Flush + commit + alloc together after 2 allocs and no commits.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 6'd32, 1, 6'd32, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 6'd31, 1, 6'd33, 1, 0, 1);
        step(1, 0, 0, 1, 1, 0, 6'd30, 1, 6'd34, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'd31, 1, 6'd33, 1, 0, 0);

        // Stall blocks the allocation but not the free.
        step(1, 1, 6'd7, 0, 0, 1, 6'd31, 1, 6'd33, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'd32, 1, 6'd33, 1, 0, 0);

        // Free into a full list, then commit with nothing outstanding.
        step(0, 1, 6'd9, 0, 0, 0, 6'd32, 1, 6'd33, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 6'd32, 1, 6'd33, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 6'd32, 1, 6'd33, 1, 1, 0);
        // Slot the dropped free would have hit still holds 33; allocate from it.
        step(1, 0, 0, 0, 0, 0, 6'd32, 1, 6'd33, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 6'd31, 1, 6'd34, 1, 0, 1);
        // Flush returns to committed head 1, proving the bad commit was ignored.
        step(0, 0, 0, 0, 1, 0, 6'd30, 1, 6'd35, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'd32, 1, 6'd33, 1, 0, 0);

        // Reset mid-sequence drops everything.
        step(1, 0, 0, 0, 0, 0, 6'd32, 1, 6'd33, 1, 0, 1);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 6'd32, 1, 6'd32, 1, 0, 0);

        @(negedge clk);
        tests++;
        if (exp_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d grants and %0d status checks left, want 0 and 0",
                     exp_q.size(), st_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
